// File: rtl/id_ex_stage_reg_if.sv
// ID/EX boundary bundle: decoder/regfile outputs toward EX plus the registered EX view.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic              id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead;
  logic              id_MemWrite, id_Branch, id_Jump, id_ExtendSel;
  logic [1:0]        id_ALUOp;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm, id_pc4;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              flush;
  logic              stall_out;
  logic              ex_valid;
  logic              ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead;
  logic              ex_MemWrite, ex_Branch, ex_Jump, ex_ExtendSel;
  logic [1:0]        ex_ALUOp;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [15:0]       bubble_cnt, flush_cnt;

  modport master (
    output id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
           id_MemWrite, id_Branch, id_Jump, id_ExtendSel, id_ALUOp,
           id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd, flush,
    input  stall_out, ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
           ex_MemWrite, ex_Branch, ex_Jump, ex_ExtendSel, ex_ALUOp,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
           bubble_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead,
           id_MemWrite, id_Branch, id_Jump, id_ExtendSel, id_ALUOp,
           id_rs_data, id_rt_data, id_imm, id_pc4, id_rs, id_rt, id_rd, flush,
    output stall_out, ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead,
           ex_MemWrite, ex_Branch, ex_Jump, ex_ExtendSel, ex_ALUOp,
           ex_rs_data, ex_rt_data, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd,
           bubble_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard bubble insertion and branch/jump flush.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  id_ex_stage_reg_if.slave  bus
);
  typedef struct packed {
    logic       reg_dst, alu_src, memto_reg, reg_write, mem_read;
    logic       mem_write, branch, jump, extend_sel;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] rs_data, rt_data, imm, pc4;
    logic [REG_AW-1:0] rs, rt, rd;
  } ops_t;

  ctrl_t       ctrl_d, ctrl_q;
  ops_t        ops_d, ops_q;
  logic        valid_q;
  logic [15:0] bubble_q, flush_q;
  logic        uses_rt, hazard, live;

  // RegDst/MemtoReg are x from the decoder whenever nothing is written back.
  assign ctrl_d = '{
    reg_dst:    bus.id_RegDst & bus.id_RegWrite,
    alu_src:    bus.id_ALUSrc,
    memto_reg:  bus.id_MemtoReg & bus.id_RegWrite,
    reg_write:  bus.id_RegWrite,
    mem_read:   bus.id_MemRead,
    mem_write:  bus.id_MemWrite,
    branch:     bus.id_Branch,
    jump:       bus.id_Jump,
    extend_sel: bus.id_ExtendSel,
    alu_op:     bus.id_ALUOp
  };

  assign ops_d = '{
    rs_data: bus.id_rs_data, rt_data: bus.id_rt_data, imm: bus.id_imm, pc4: bus.id_pc4,
    rs: bus.id_rs, rt: bus.id_rt, rd: bus.id_rd
  };

  // A real opcode always does at least one of these; an all-x decode fails the test.
  assign live    = bus.id_valid & (bus.id_RegWrite | bus.id_MemWrite | bus.id_Branch | bus.id_Jump);
  assign uses_rt = bus.id_RegDst | bus.id_MemWrite | (bus.id_Branch & ~bus.id_Jump);
  assign hazard  = bus.id_valid & valid_q & ctrl_q.mem_read & (ops_q.rt != {REG_AW{1'b0}})
                 & ((ops_q.rt == bus.id_rs) | (uses_rt & (ops_q.rt == bus.id_rt)));
  assign bus.stall_out = hazard & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      ops_q    <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      ops_q <= ops_d;
      if (bus.flush) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        if (flush_q != 16'hFFFF) flush_q <= flush_q + 16'd1;
      end else if (hazard) begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
        if (bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
      end else if (live) begin
        valid_q <= 1'b1;
        ctrl_q  <= ctrl_d;
      end else begin
        valid_q <= 1'b0;
        ctrl_q  <= '0;
      end
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_RegDst    = ctrl_q.reg_dst;
  assign bus.ex_ALUSrc    = ctrl_q.alu_src;
  assign bus.ex_MemtoReg  = ctrl_q.memto_reg;
  assign bus.ex_RegWrite  = ctrl_q.reg_write;
  assign bus.ex_MemRead   = ctrl_q.mem_read;
  assign bus.ex_MemWrite  = ctrl_q.mem_write;
  assign bus.ex_Branch    = ctrl_q.branch;
  assign bus.ex_Jump      = ctrl_q.jump;
  assign bus.ex_ExtendSel = ctrl_q.extend_sel;
  assign bus.ex_ALUOp     = ctrl_q.alu_op;
  assign bus.ex_rs_data   = ops_q.rs_data;
  assign bus.ex_rt_data   = ops_q.rt_data;
  assign bus.ex_imm       = ops_q.imm;
  assign bus.ex_pc4       = ops_q.pc4;
  assign bus.ex_rs        = ops_q.rs;
  assign bus.ex_rt        = ops_q.rt;
  assign bus.ex_rd        = ops_q.rd;
  assign bus.bubble_cnt   = bubble_q;
  assign bus.flush_cnt    = flush_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed table-driven bench for the ID/EX register: hazards, flush, scrubbing, saturation.
module tb_id_ex_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;

  id_ex_stage_reg_if #(.DATA_W(32), .REG_AW(5)) bus();
  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef enum logic [2:0] {OP_LW, OP_ADDU, OP_ADDIU, OP_SW, OP_BEQ} op_e;

  // {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ExtendSel, ALUOp}
  localparam logic [10:0] LWC   = 11'b01111000100;
  localparam logic [10:0] ADDUC = 11'b10010000010;
  localparam logic [10:0] ADDIC = 11'b01010000100;
  localparam logic [10:0] SWC   = 11'b01000100100;
  localparam logic [10:0] BEQC  = 11'b00000010101;

  typedef struct {
    op_e        op;
    logic [4:0] rs, rt, rd;
    logic       valid, flush;
    logic       stall, ev;
    logic [10:0] ctrl;
    logic [15:0] bub, fl;
  } vec_t;

  vec_t vt[19];

  function automatic vec_t mk(op_e op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                              logic valid, logic flush, logic stall, logic ev,
                              logic [10:0] ctrl, logic [15:0] bub, logic [15:0] fl);
    vec_t v;
    v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.valid = valid; v.flush = flush;
    v.stall = stall; v.ev = ev; v.ctrl = ctrl; v.bub = bub; v.fl = fl;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ex_ctrl();
    return {bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_RegWrite, bus.ex_MemRead,
            bus.ex_MemWrite, bus.ex_Branch, bus.ex_Jump, bus.ex_ExtendSel, bus.ex_ALUOp};
  endfunction

  // Raw decoder output, including the x fields it produces for SW/BEQ.
  task automatic drive(op_e op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                       logic valid, logic flush, logic [31:0] pc4);
    logic [10:0] raw;
    case (op)
      OP_LW:    raw = LWC;
      OP_ADDU:  raw = ADDUC;
      OP_ADDIU: raw = ADDIC;
      OP_SW:    raw = 11'bx1x00100100;
      default:  raw = 11'bx0x00010101;
    endcase
    {bus.id_RegDst, bus.id_ALUSrc, bus.id_MemtoReg, bus.id_RegWrite, bus.id_MemRead,
     bus.id_MemWrite, bus.id_Branch, bus.id_Jump, bus.id_ExtendSel, bus.id_ALUOp} = raw;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = 32'h100 + 32'(rs);
    bus.id_rt_data = 32'h200 + 32'(rt);
    bus.id_imm = 32'h1234;
    bus.id_pc4 = pc4;
    bus.id_valid = valid;
    bus.flush = flush;
  endtask

  initial begin
    // lw/use, $0, rt-only dest, sw scrub, flush, flush+hazard, invalid, branch via rt
    vt[0]  = mk(OP_LW,    1, 2, 0, 1, 0, 0, 1, LWC,   0, 0);
    vt[1]  = mk(OP_ADDU,  2, 4, 3, 1, 0, 1, 0, 11'd0, 1, 0);
    vt[2]  = mk(OP_ADDU,  2, 4, 3, 1, 0, 0, 1, ADDUC, 1, 0);
    vt[3]  = mk(OP_LW,    1, 0, 0, 1, 0, 0, 1, LWC,   1, 0);
    vt[4]  = mk(OP_ADDU,  0, 0, 3, 1, 0, 0, 1, ADDUC, 1, 0);
    vt[5]  = mk(OP_LW,    1, 2, 0, 1, 0, 0, 1, LWC,   1, 0);
    vt[6]  = mk(OP_ADDIU, 2, 5, 0, 1, 0, 1, 0, 11'd0, 2, 0);
    vt[7]  = mk(OP_ADDIU, 2, 5, 0, 1, 0, 0, 1, ADDIC, 2, 0);
    vt[8]  = mk(OP_LW,    1, 2, 0, 1, 0, 0, 1, LWC,   2, 0);
    vt[9]  = mk(OP_ADDIU, 7, 2, 0, 1, 0, 0, 1, ADDIC, 2, 0);
    vt[10] = mk(OP_SW,    1, 3, 0, 1, 0, 0, 1, SWC,   2, 0);
    vt[11] = mk(OP_BEQ,   3, 4, 0, 1, 1, 0, 0, 11'd0, 2, 1);
    vt[12] = mk(OP_LW,    1, 2, 0, 1, 0, 0, 1, LWC,   2, 1);
    vt[13] = mk(OP_ADDU,  2, 4, 3, 1, 1, 0, 0, 11'd0, 2, 2);
    vt[14] = mk(OP_BEQ,   1, 2, 0, 1, 0, 0, 1, BEQC,  2, 2);
    vt[15] = mk(OP_LW,    1, 2, 0, 0, 0, 0, 0, 11'd0, 2, 2);
    vt[16] = mk(OP_LW,    1, 2, 0, 1, 0, 0, 1, LWC,   2, 2);
    vt[17] = mk(OP_BEQ,   5, 2, 0, 1, 0, 1, 0, 11'd0, 3, 2);
    vt[18] = mk(OP_BEQ,   5, 2, 0, 1, 0, 0, 1, BEQC,  3, 2);

    // reset with random inputs
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      drive(OP_LW, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b0, $urandom);
      bus.id_rs_data = $urandom;
      @(posedge clk); #1;
      chk("rst_valid", 32'(bus.ex_valid), 0);
      chk("rst_ctrl", 32'(ex_ctrl()), 0);
      chk("rst_rs_data", bus.ex_rs_data, 0);
      chk("rst_pc4", bus.ex_pc4, 0);
      chk("rst_rt", 32'(bus.ex_rt), 0);
      chk("rst_cnts", {bus.bubble_cnt, bus.flush_cnt}, 0);
      chk("rst_stall", 32'(bus.stall_out), 0);
      @(negedge clk);
    end
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      drive(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].valid, vt[i].flush, 32'(i * 4));
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.stall_out), 32'(vt[i].stall));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(bus.ex_valid), 32'(vt[i].ev));
      chk($sformatf("v%0d_ctrl", i), 32'(ex_ctrl()), 32'(vt[i].ctrl));
      chk($sformatf("v%0d_bub", i), 32'(bus.bubble_cnt), 32'(vt[i].bub));
      chk($sformatf("v%0d_fl", i), 32'(bus.flush_cnt), 32'(vt[i].fl));
      if (vt[i].ev) begin
        chk($sformatf("v%0d_rt", i), 32'(bus.ex_rt), 32'(vt[i].rt));
        chk($sformatf("v%0d_rd", i), 32'(bus.ex_rd), 32'(vt[i].rd));
        chk($sformatf("v%0d_rsd", i), bus.ex_rs_data, 32'h100 + 32'(vt[i].rs));
        chk($sformatf("v%0d_pc4", i), bus.ex_pc4, 32'(i * 4));
      end
      @(negedge clk);
    end

    // reset while a stall is asserted
    drive(OP_LW, 1, 2, 0, 1, 0, 32'h80);
    @(posedge clk); @(negedge clk);
    drive(OP_ADDU, 2, 4, 3, 1, 0, 32'h84);
    #1 chk("mid_stall_pre", 32'(bus.stall_out), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_valid", 32'(bus.ex_valid), 0);
    chk("mid_ctrl", 32'(ex_ctrl()), 0);
    chk("mid_cnts", {bus.bubble_cnt, bus.flush_cnt}, 0);
    chk("mid_stall", 32'(bus.stall_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // bubble counter saturation
    drive(OP_LW, 1, 2, 0, 1, 0, 32'h90);
    @(posedge clk); @(negedge clk);
    force dut.bubble_q = 16'hFFFE;
    #1 release dut.bubble_q;
    drive(OP_ADDU, 2, 4, 3, 1, 0, 32'h94);
    #1 chk("sat_stall1", 32'(bus.stall_out), 1);
    @(posedge clk); #1;
    chk("sat_ffff1", 32'(bus.bubble_cnt), 32'hFFFF);
    @(posedge clk); @(negedge clk);
    drive(OP_LW, 1, 2, 0, 1, 0, 32'h98);
    @(posedge clk); @(negedge clk);
    drive(OP_ADDU, 2, 4, 3, 1, 0, 32'h9C);
    #1 chk("sat_stall2", 32'(bus.stall_out), 1);
    @(posedge clk); #1;
    chk("sat_ffff2", 32'(bus.bubble_cnt), 32'hFFFF);
    chk("sat_fl", 32'(bus.flush_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
